pe_accum_ctrl: RTL and testbench

PE_ACCUM_CTRL -- requirements
Module: pe_accum_ctrl

---
 rtl/pe_accum_ctrl.sv | 137 +++++++++++++
 tb/tb_pe_accum_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pe_accum_ctrl
// Brief  : Job controller that streams operand chunks into an external
//          mul_add datapath and accumulates its dot results onto a bias.
// Rev    : 1.0
// ============================================================================
module pe_accum_ctrl #(
    parameter int LEN_W = 12
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [31:0]      cfg_bias,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_feature,
    input  logic [127:0]     in_filter,
    output logic [127:0]     dp_feature,
    output logic [127:0]     dp_filter,
    input  logic [31:0]      dp_dot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    input  logic             abort,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_acc;
    logic [LEN_W-1:0] r_remain;
    logic             r_op_vld;
    logic [127:0]     r_dp_feature;
    logic [127:0]     r_dp_filter;

    logic             w_cfg_ready;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_cfg_take;

    assign w_accept   = in_valid & w_in_ready;
    assign w_cfg_take = cfg_valid & w_cfg_ready;

    always_comb begin
        w_next      = r_state;
        w_cfg_ready = 1'b0;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cfg_ready = 1'b1;
                if (cfg_valid) begin
                    w_next = (cfg_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                w_in_ready = 1'b1;
                if (in_valid && (r_remain == LEN_W'(1))) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (abort) begin
            w_next = S_IDLE;
        end
    end

    // Abort freezes the accumulator so the value of the in-flight operand is dropped.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_acc        <= '0;
            r_remain     <= '0;
            r_op_vld     <= 1'b0;
            r_dp_feature <= '0;
            r_dp_filter  <= '0;
        end else if (abort) begin
            r_state      <= S_IDLE;
            r_op_vld     <= 1'b0;
            r_dp_feature <= '0;
            r_dp_filter  <= '0;
        end else begin
            r_state <= w_next;
            if (w_cfg_take) begin
                r_acc    <= cfg_bias;
                r_remain <= cfg_len;
            end else if (r_op_vld) begin
                r_acc <= r_acc + dp_dot;
            end
            if (w_accept) begin
                r_dp_feature <= in_feature;
                r_dp_filter  <= in_filter;
                r_op_vld     <= 1'b1;
                if (r_remain != '0) begin
                    r_remain <= r_remain - LEN_W'(1);
                end
            end else begin
                r_dp_feature <= '0;
                r_dp_filter  <= '0;
                r_op_vld     <= 1'b0;
            end
        end
    end

    assign cfg_ready  = w_cfg_ready;
    assign in_ready   = w_in_ready;
    assign out_valid  = w_out_valid;
    assign out_sum    = r_acc;
    assign dp_feature = r_dp_feature;
    assign dp_filter  = r_dp_filter;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pe_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_pe_accum_ctrl
// Brief  : Directed self-checking bench for pe_accum_ctrl with a mul_add model.
// Rev    : 1.0
// ============================================================================
module tb_pe_accum_ctrl;

    localparam int LEN_W = 12;

    logic             clock = 1'b0;
    logic             resetn;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [LEN_W-1:0] cfg_len;
    logic [31:0]      cfg_bias;
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_feature;
    logic [127:0]     in_filter;
    logic [127:0]     dp_feature;
    logic [127:0]     dp_filter;
    logic [31:0]      dp_dot;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_sum;
    logic             abort;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    pe_accum_ctrl #(.LEN_W(LEN_W)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_len    (cfg_len),
        .cfg_bias   (cfg_bias),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_feature (in_feature),
        .in_filter  (in_filter),
        .dp_feature (dp_feature),
        .dp_filter  (dp_filter),
        .dp_dot     (dp_dot),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .abort      (abort),
        .busy       (busy)
    );

    // Shift-coded weights: bit7 = negate, bits[2:0] = left-shift of the int8 feature.
    function automatic logic [31:0] mul_add(input logic [127:0] f, input logic [127:0] w);
        logic signed [31:0] s;
        logic signed [31:0] x;
        s = 0;
        for (int i = 0; i < 16; i++) begin
            x = 32'(signed'(f[8*i +: 8]));
            x = x <<< w[8*i +: 3];
            s = w[8*i+7] ? (s - x) : (s + x);
        end
        return s;
    endfunction

    assign dp_dot = mul_add(dp_feature, dp_filter);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic start_job(input int len, input logic [31:0] bias);
        cfg_len   = LEN_W'(len);
        cfg_bias  = bias;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    // Feeds len chunks (optionally with in_valid toggling), then checks result timing, hold and release.
    task automatic run_job(input string tag, input int len, input logic [31:0] bias,
                           input logic [7:0] feat, input logic [7:0] filt,
                           input bit gap, input int hold, input logic [31:0] exp);
        int  n_acc;
        int  t;
        int  lat;
        logic w;
        check_eq({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
        start_job(len, bias);
        n_acc = 0;
        t     = 0;
        while (n_acc < len && t < 200) begin
            in_feature = {120'd0, feat};
            in_filter  = {120'd0, filt};
            in_valid   = !(gap && (t % 2 == 1));
            w          = in_valid & in_ready;
            tick();
            if (w) n_acc++;
            t++;
        end
        in_valid = 1'b0;
        check_eq({tag, "_accepts"}, 32'(n_acc), 32'(len));
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check_eq({tag, "_latency"}, 32'(lat), (len == 0) ? 32'd0 : 32'd1);
        for (int h = 0; h < hold; h++) begin
            check_eq({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check_eq({tag, "_hold_sum"}, out_sum, exp);
            tick();
        end
        check_eq({tag, "_sum"}, out_sum, exp);
        check_eq({tag, "_done_in_ready"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        check_eq({tag, "_done_cfg_ready"}, 32'(cfg_ready), 32'd0);
        tick();
        out_ready = 1'b0;
        check_eq({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    // Starts a 4-chunk job (dot 12 each) and feeds two chunks; stops with in_valid still high.
    task automatic partial_job();
        start_job(4, 32'd0);
        in_feature = {120'd0, 8'h03};
        in_filter  = {120'd0, 8'h02};
        in_valid   = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn     = 1'b0;
        cfg_valid  = 1'b0;
        cfg_len    = '0;
        cfg_bias   = '0;
        in_valid   = 1'b0;
        in_feature = '0;
        in_filter  = '0;
        out_ready  = 1'b0;
        abort      = 1'b0;
        do_reset();

        check_eq("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_sum", out_sum, 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_dp_zero", 32'(|{dp_feature, dp_filter}), 32'd0);
        check_eq("rst_dp_dot", dp_dot, 32'd0);

        // Basic: 100 + 3*(3<<2) = 136
        run_job("basic", 3, 32'd100, 8'h03, 8'h02, 1'b0, 0, 32'd136);
        // Negative weights with gaps and backpressure: 2 * -(3<<1) = -12
        run_job("neg", 2, 32'd0, 8'h03, 8'h81, 1'b1, 5, 32'hFFFF_FFF4);
        // Zero length: bias -7 straight to DONE
        run_job("zero", 0, 32'hFFFF_FFF9, 8'h03, 8'h02, 1'b0, 1, 32'hFFFF_FFF9);
        // Wrap: 0x7FFFFFF0 + (8<<2)
        run_job("wrap", 1, 32'h7FFF_FFF0, 8'h08, 8'h02, 1'b0, 0, 32'h8000_0010);

        // Abort after two accepts: acc holds 12 (second dot dropped), no result
        partial_job();
        check_eq("abort_run_in_ready", 32'(in_ready), 32'd1);
        abort = 1'b1;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_cfg_ready", 32'(cfg_ready), 32'd1);
        check_eq("abort_acc_frozen", out_sum, 32'd12);
        check_eq("abort_dp_zero", 32'(|{dp_feature, dp_filter}), 32'd0);
        tick();
        tick();
        check_eq("abort_no_valid", 32'(out_valid), 32'd0);
        run_job("post_abort", 1, 32'd5, 8'h03, 8'h02, 1'b0, 0, 32'd17);

        // Reset mid-job, with abort also high to show reset wins
        partial_job();
        resetn = 1'b0;
        abort  = 1'b1;
        tick();
        resetn   = 1'b1;
        abort    = 1'b0;
        in_valid = 1'b0;
        check_eq("rstjob_busy", 32'(busy), 32'd0);
        check_eq("rstjob_out_sum", out_sum, 32'd0);
        check_eq("rstjob_dp_zero", 32'(|{dp_feature, dp_filter}), 32'd0);
        tick();
        check_eq("rstjob_no_valid", 32'(out_valid), 32'd0);
        run_job("post_reset", 1, 32'd5, 8'h03, 8'h02, 1'b0, 0, 32'd17);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
